// File: rtl/baud_pkg.sv
// Shared types and defaults for the UART baud tick scheduler.
package baud_pkg;

  localparam int unsigned DIV_W_DEF       = 16;
  localparam int unsigned OSR_DEF         = 16;
  localparam int unsigned DEFAULT_DIV_DEF = 651;
  localparam int unsigned MIN_DIV         = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..limit on inc, wrap flags the terminal increment.
module mod_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/baud_tick_ctrl.sv
// Programmable baud tick scheduler: shared prescaler feeding oversample and bit strobes,
// with divisor changes deferred to bit boundaries while running.
module baud_tick_ctrl
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned OSR         = OSR_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             inp_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             running
);

  localparam int unsigned OS_W = (OSR > 2) ? $clog2(OSR) : 1;

  state_t             state;
  state_t             state_nx;
  logic               pend;
  logic               pend_nx;
  logic [DIV_W-1:0]   pend_div;
  logic [DIV_W-1:0]   pend_div_nx;
  logic [DIV_W-1:0]   cur_div_nx;
  logic               rx_nx;
  logic               tx_nx;
  logic               err_nx;
  logic               ready_nx;

  logic               live;
  logic               hs;
  logic               bad;
  logic               cnt_clr;
  logic [DIV_W-1:0]   pre_limit;
  logic [DIV_W-1:0]   pre_cnt;
  logic               pre_wrap;
  logic [OS_W-1:0]    os_cnt;
  logic               os_wrap;

  // Counts are only observed through the wrap flags.
  logic               unused_cnt;
  assign unused_cnt = ^{pre_cnt, os_cnt};

  assign live      = (state == RUN) && en;
  assign hs        = cfg_valid && cfg_ready;
  assign bad       = cfg_div < DIV_W'(MIN_DIV);
  assign cnt_clr   = !live || sync;
  assign pre_limit = cur_div - DIV_W'(1);

  mod_counter #(.W(DIV_W)) u_pre (
    .clk   (inp_clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (state == RUN),
    .limit (pre_limit),
    .count (pre_cnt),
    .wrap  (pre_wrap)
  );

  mod_counter #(.W(OS_W)) u_os (
    .clk   (inp_clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pre_wrap),
    .limit (OS_W'(OSR - 1)),
    .count (os_cnt),
    .wrap  (os_wrap)
  );

  always_ff @(posedge inp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_tick   <= 1'b0;
      tx_tick   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
      running   <= 1'b0;
      cur_div   <= DIV_W'(DEFAULT_DIV);
      pend      <= 1'b0;
      pend_div  <= '0;
    end else begin
      state     <= state_nx;
      rx_tick   <= rx_nx;
      tx_tick   <= tx_nx;
      cfg_err   <= err_nx;
      cfg_ready <= ready_nx;
      running   <= (state_nx == RUN);
      cur_div   <= cur_div_nx;
      pend      <= pend_nx;
      pend_div  <= pend_div_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    rx_nx       = 1'b0;
    tx_nx       = 1'b0;
    err_nx      = hs && bad;
    ready_nx    = cfg_ready;
    cur_div_nx  = cur_div;
    pend_nx     = pend;
    pend_div_nx = pend_div;

    unique case (state)
      IDLE: if (en)  state_nx = RUN;
      RUN:  if (!en) state_nx = IDLE;
    endcase

    // sync beats a coincident wrap: no strobe, no pending apply.
    if (live && !sync && pre_wrap) begin
      rx_nx = 1'b1;
      tx_nx = os_wrap;
    end

    if (!live) begin
      if (pend) begin
        cur_div_nx = pend_div;
        pend_nx    = 1'b0;
        ready_nx   = 1'b1;
      end
      if (hs && !bad) cur_div_nx = cfg_div;
    end else begin
      if (tx_nx && pend) begin
        cur_div_nx = pend_div;
        pend_nx    = 1'b0;
        ready_nx   = 1'b1;
      end
      if (hs && !bad) begin
        pend_nx     = 1'b1;
        pend_div_nx = cfg_div;
        ready_nx    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Bench for baud_tick_ctrl: expected tick cycles queued as stimulus is driven, checked by a monitor.
module tb_baud_tick_ctrl;

  localparam int unsigned DW  = 16;
  localparam int unsigned OSR = 4;
  localparam int unsigned DEF = 4;

  logic          inp_clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sync;
  logic [DW-1:0] cfg_div;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic          rx_tick;
  logic          tx_tick;
  logic [DW-1:0] cur_div;
  logic          running;

  baud_tick_ctrl #(.DIV_W(DW), .OSR(OSR), .DEFAULT_DIV(DEF)) dut (
    .inp_clk   (inp_clk),
    .rst_n     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick),
    .cur_div   (cur_div),
    .running   (running)
  );

  always #5 inp_clk = ~inp_clk;

  int cyc = 0;
  always @(posedge inp_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  typedef struct {
    int cyc;
    bit tx;
  } ev_t;
  ev_t q[$];

  task automatic push_ev(input int c, input bit tx);
    ev_t e;
    e.cyc = c;
    e.tx  = tx;
    q.push_back(e);
  endtask

  // Expected strobes for a run started at edge t0 with divisor d.
  task automatic push_run(input int t0, input int d, input int n);
    for (int k = 1; k <= n; k++) push_ev(t0 + k * d, (k % OSR) == 0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge inp_clk);
  endtask

  task automatic idle_cfg(input logic [DW-1:0] d);
    @(negedge inp_clk);
    cfg_div   = d;
    cfg_valid = 1'b1;
    @(negedge inp_clk);
    cfg_valid = 1'b0;
  endtask

  // Tick monitor: any strobe or expected strobe is a comparison.
  bit   mon_on = 1'b0;
  logic m_rx;
  logic m_tx;
  always @(negedge inp_clk) begin
    if (mon_on) begin
      m_rx = 1'b0;
      m_tx = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        m_rx = 1'b1;
        m_tx = q[0].tx;
        void'(q.pop_front());
      end
      if (m_rx || m_tx || rx_tick || tx_tick) begin
        chk_b("rx_tick", rx_tick, m_rx);
        chk_b("tx_tick", tx_tick, m_tx);
      end
    end
  end

  typedef struct {
    logic [DW-1:0] div;
    logic          valid;
    logic          err;
    logic [DW-1:0] cur;
  } vec_t;
  vec_t vt[7];

  int t0;

  initial begin
    vt[0] = '{div: 16'd6,     valid: 1'b1, err: 1'b0, cur: 16'd6};
    vt[1] = '{div: 16'd1,     valid: 1'b1, err: 1'b1, cur: 16'd6};
    vt[2] = '{div: 16'd0,     valid: 1'b1, err: 1'b1, cur: 16'd6};
    vt[3] = '{div: 16'd9,     valid: 1'b0, err: 1'b0, cur: 16'd6};
    vt[4] = '{div: 16'd2,     valid: 1'b1, err: 1'b0, cur: 16'd2};
    vt[5] = '{div: 16'hFFFF,  valid: 1'b1, err: 1'b0, cur: 16'hFFFF};
    vt[6] = '{div: 16'd6,     valid: 1'b1, err: 1'b0, cur: 16'd6};

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (2) @(negedge inp_clk);
    chk_b("rst_rx", rx_tick, 1'b0);
    chk_b("rst_tx", tx_tick, 1'b0);
    chk_b("rst_err", cfg_err, 1'b0);
    chk_b("rst_running", running, 1'b0);
    chk_b("rst_ready", cfg_ready, 1'b1);
    chk_d("rst_cur_div", cur_div, 16'(DEF));
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Default divisor run: rx every 4, tx every 16.
    @(negedge inp_clk);
    t0 = cyc + 1; en = 1'b1;
    push_run(t0, 4, 8);
    @(negedge inp_clk);
    chk_b("run_running", running, 1'b1);
    wait_cyc(t0 + 32);
    en = 1'b0;
    @(negedge inp_clk);
    chk_b("idle_running", running, 1'b0);

    // IDLE config vectors.
    for (int i = 0; i < 7; i++) begin
      @(negedge inp_clk);
      cfg_div   = vt[i].div;
      cfg_valid = vt[i].valid;
      @(negedge inp_clk);
      cfg_valid = 1'b0;
      chk_b($sformatf("vec%0d_err", i), cfg_err, vt[i].err);
      chk_d($sformatf("vec%0d_cur", i), cur_div, vt[i].cur);
      chk_b($sformatf("vec%0d_ready", i), cfg_ready, 1'b1);
      @(negedge inp_clk);
      chk_b($sformatf("vec%0d_err_clr", i), cfg_err, 1'b0);
    end

    // Run at divisor 6.
    t0 = cyc + 1; en = 1'b1;
    push_run(t0, 6, 8);
    wait_cyc(t0 + 48);
    en = 1'b0;
    @(negedge inp_clk);

    // Divisor change while running takes effect at the bit boundary.
    idle_cfg(16'd4);
    t0 = cyc + 1; en = 1'b1;
    push_run(t0, 4, 4);
    push_run(t0 + 16, 8, 5);
    wait_cyc(t0 + 4);
    cfg_div = 16'd8; cfg_valid = 1'b1;
    @(negedge inp_clk);
    cfg_valid = 1'b0;
    chk_b("pend_ready_low", cfg_ready, 1'b0);
    wait_cyc(t0 + 15);
    chk_b("pend_ready_hold", cfg_ready, 1'b0);
    chk_d("pend_cur_old", cur_div, 16'd4);
    @(negedge inp_clk);
    chk_b("pend_ready_back", cfg_ready, 1'b1);
    chk_d("pend_cur_new", cur_div, 16'd8);

    // Rejected request while running.
    wait_cyc(t0 + 50);
    cfg_div = 16'd1; cfg_valid = 1'b1;
    @(negedge inp_clk);
    cfg_valid = 1'b0;
    chk_b("run_rej_err", cfg_err, 1'b1);
    chk_b("run_rej_ready", cfg_ready, 1'b1);
    @(negedge inp_clk);
    chk_b("run_rej_err_clr", cfg_err, 1'b0);
    chk_d("run_rej_cur", cur_div, 16'd8);
    wait_cyc(t0 + 56);
    en = 1'b0;
    @(negedge inp_clk);

    // sync realigns phase.
    idle_cfg(16'd4);
    t0 = cyc + 1; en = 1'b1;
    push_ev(t0 + 4, 1'b0);
    push_ev(t0 + 11, 1'b0);
    push_ev(t0 + 15, 1'b0);
    push_ev(t0 + 19, 1'b0);
    push_ev(t0 + 23, 1'b1);
    wait_cyc(t0 + 6);
    sync = 1'b1;
    @(negedge inp_clk);
    sync = 1'b0;
    wait_cyc(t0 + 23);
    en = 1'b0;
    @(negedge inp_clk);

    // Dropping en applies a pending divisor.
    t0 = cyc + 1; en = 1'b1;
    push_ev(t0 + 4, 1'b0);
    wait_cyc(t0 + 1);
    cfg_div = 16'd8; cfg_valid = 1'b1;
    @(negedge inp_clk);
    cfg_valid = 1'b0;
    chk_b("stop_ready_low", cfg_ready, 1'b0);
    wait_cyc(t0 + 6);
    en = 1'b0;
    @(negedge inp_clk);
    chk_d("stop_cur_applied", cur_div, 16'd8);
    chk_b("stop_ready_back", cfg_ready, 1'b1);
    chk_b("stop_running", running, 1'b0);

    // Asynchronous reset during a tick with a request pending.
    idle_cfg(16'd5);
    t0 = cyc + 1; en = 1'b1;
    push_ev(t0 + 5, 1'b0);
    wait_cyc(t0 + 2);
    cfg_div = 16'd8; cfg_valid = 1'b1;
    @(negedge inp_clk);
    cfg_valid = 1'b0;
    wait_cyc(t0 + 5);
    chk_b("prerst_rx", rx_tick, 1'b1);
    #1 rst_n = 1'b0; en = 1'b0;
    #1;
    chk_b("arst_rx", rx_tick, 1'b0);
    chk_b("arst_tx", tx_tick, 1'b0);
    chk_b("arst_running", running, 1'b0);
    chk_b("arst_ready", cfg_ready, 1'b1);
    chk_d("arst_cur", cur_div, 16'(DEF));
    @(negedge inp_clk);
    rst_n = 1'b1;
    @(negedge inp_clk);
    chk_d("postrst_cur", cur_div, 16'(DEF));
    t0 = cyc + 1; en = 1'b1;
    push_run(t0, 4, 4);
    wait_cyc(t0 + 16);
    chk_d("postrst_no_pend", cur_div, 16'(DEF));
    en = 1'b0;
    repeat (2) @(negedge inp_clk);
    chk_d("queue_empty", 16'(q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/baud_tick_ctrl.md
Name: baud_tick_ctrl

Overview:
Run-time programmable baud-rate tick scheduler for the UART.
- Replaces free-running fixed-ratio division with one shared prescaler.
- Produces a single-cycle oversample strobe (rx_tick) for the receiver and a bit-rate strobe (tx_tick) for the transmitter.
- Accepts divisor updates through a valid/ready handshake and applies them only at bit boundaries, so an in-flight bit is never stretched or truncated.

Parameters:
- DIV_W, 16: width of divisor and prescaler counter.
- OSR, 16: oversample ratio (rx_tick periods per tx_tick period); must be ≥2.
- DEFAULT_DIV, 651: divisor loaded at reset (100 MHz / (9600 × 16)).

Ports:
- inp_clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: run enable; low forces IDLE.
- sync, input, 1: phase restart pulse (RX start-edge realignment).
- cfg_div, input, DIV_W: requested divisor.
- cfg_valid, input, 1: divisor request valid.
- cfg_ready, output, 1: block can accept a request.
- cfg_err, output, 1: one-cycle pulse, request rejected.
- rx_tick, output, 1: oversample strobe, one cycle wide.
- tx_tick, output, 1: bit strobe, one cycle wide.
- cur_div, output, DIV_W: divisor currently in effect.
- running, output, 1: high in RUN state.

Behaviour:
- Reset values:
  - Outputs: rx_tick=0, tx_tick=0, cfg_err=0, running=0, cfg_ready=1.
  - State: cur_div=DEFAULT_DIV, pending flag=0.
  - Counters: pre_cnt=0, os_cnt=0, state=IDLE.
- States:
  - IDLE → RUN when en=1 (sampled at a clock edge; that edge clears pre_cnt and os_cnt).
  - RUN → IDLE when en=0; counters clear, no ticks in the following cycle.
- RUN counting:
  - pre_cnt increments each cycle and wraps at cur_div−1.
  - rx_tick is registered and high in the cycle after the edge where pre_cnt wraps, so its period is exactly cur_div cycles.
  - First rx_tick appears cur_div cycles after the IDLE→RUN edge.
  - os_cnt increments on each wrap and wraps at OSR−1.
  - tx_tick is asserted together with the rx_tick on which os_cnt wraps (period cur_div × OSR).
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_div < 2: rejected, cfg_err pulses in the next cycle, nothing stored.
  - IDLE: cur_div is updated at the handshake edge.
  - RUN: value is stored as pending and cfg_ready drops until it is applied.
  - Pending value is applied at the edge producing a tx_tick (the os_cnt wrap). At that edge pre_cnt and os_cnt clear, so the next bit runs fully at the new rate.
  - A rejected request in RUN does not lower cfg_ready.
- sync=1 in RUN: pre_cnt and os_cnt clear; no tick is produced from that edge. A pending divisor is not applied by sync.
- Simultaneous events:
  - en=0 with a pending value: pending is applied immediately on entering IDLE.
  - en=0 with a handshake: request accepted under IDLE rules.
  - sync on a wrap edge: sync wins, no tick.
- Mid-operation reset clears all state asynchronously; ticks stop immediately.
- Widths: all compares are at DIV_W bits. cur_div × OSR is never computed; no overflow is possible.

Decomposition:
- Package baud_pkg holds:
  - state enum (IDLE, RUN)
  - MIN_DIV=2
  - DIV_W and OSR defaults
- Sub-module mod_counter (parameter W; inputs clr, inc, limit; outputs count, wrap).
  - Instantiated twice: once as prescaler, once as oversample counter.

Test Plan:
- Reset then en=1, DEFAULT_DIV=4, OSR=4 → rx_tick at cycles 4, 8, 12…; tx_tick at cycles 16, 32; running=1.
- In IDLE, cfg_div=6 handshake, then en=1 → cur_div=6 immediately; rx_tick period 6, tx_tick period 24.
- In RUN at div 4, request div 8 at cycle 5 → cfg_ready=0 until cycle 16; then tx_tick at 16, rx_tick at 24, 32…, next tx_tick at 48; cfg_ready back to 1.
- cfg_div=1 with cfg_valid → cfg_err pulse for one cycle; cur_div unchanged; cfg_ready stays 1.
- sync at cycle 7 (div 4) → no tick at 8; next rx_tick at 11; os_cnt restarts so tx_tick arrives 16 cycles after sync.
- rst_n low mid-bit with a pending request → outputs return to reset values in the same cycle; pending is discarded; cur_div=DEFAULT_DIV.
